// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the parametrised shift register.
// Optional parity output is enabled by defining SHIFTREG_PARITY_EN.
package shiftreg_pkg;

    // Shift direction: UP moves bits toward the MSB, DOWN toward the LSB.
    typedef enum logic {
        SHIFT_UP   = 1'b0,
        SHIFT_DOWN = 1'b1
    } shift_dir_t;

    // Smallest width for which the serial in/out slices are well formed.
    localparam int unsigned SHIFTREG_MIN_WIDTH = 2;

endpackage

// File: rtl/shift_frame_cnt.sv
// Modulo-WIDTH frame counter.
// Counts shifts and raises a registered one-cycle wrap pulse on the WIDTH-th shift.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : restart the frame (takes priority over inc)
//   inc        : count one shift
//   wrap       : registered pulse, high for the cycle after the last shift of a frame
module shift_frame_cnt
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic wrap
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    // Next count; explicit wrap so non-power-of-two widths work.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: rtl/shiftreg_n.sv
// Parametrised serial/parallel shift register with run-time direction and
// frame-complete pulse.
// Build option: define SHIFTREG_PARITY_EN to drive par with the even parity of q;
// otherwise par is tied low.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   en         : shift one position this cycle
//   load       : parallel load of din (overrides en)
//   din        : parallel load data
//   dir        : 0 = shift toward MSB (sin -> bit 0), 1 = toward LSB (sin -> MSB)
//   sin        : serial input
//   q          : register contents
//   sout       : serial output, bit leaving in the current direction
//   done       : one-cycle pulse after every WIDTH shifts
//   par        : XOR of q (parity build only)
module shiftreg_n
    import shiftreg_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             done,
    output logic             par
);

    generate
        if (WIDTH < SHIFTREG_MIN_WIDTH) begin : g_width_chk
            $error("shiftreg_n: WIDTH must be at least %0d", SHIFTREG_MIN_WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    shift_dir_t       dir_e;

    assign dir_e = shift_dir_t'(dir);

    // Register update: load beats shift beats hold.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (en) begin
            if (dir_e == SHIFT_DOWN) begin
                shreg_d = {sin, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], sin};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= RESET_VAL;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // A load restarts the frame; a load cycle never counts as a shift.
    shift_frame_cnt #(
        .WIDTH (WIDTH)
    ) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .inc   (en & ~load),
        .wrap  (done)
    );

    assign q    = shreg_q;
    assign sout = (dir_e == SHIFT_DOWN) ? shreg_q[0] : shreg_q[WIDTH-1];

`ifdef SHIFTREG_PARITY_EN
    assign par = ^shreg_q;
`else
    assign par = 1'b0;
`endif

endmodule
